// File: rtl/fetch_stage_pkg.sv
// ============================================================================
//  Module      : cpu_types / types_pkg
//  Description : Shared word type plus fetch-buffer entry and fetch FSM types.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_types;
    typedef logic [31:0] word_t;
endpackage

package types_pkg;
    import cpu_types::*;

    typedef struct packed {
        word_t instr;
        word_t pc;
        logic  pred_taken;
        word_t pred_target;
    } fetch_entry_t;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        SQUASH = 2'd1,
        HALTED = 2'd2
    } fetch_state_t;
endpackage

`default_nettype wire

// File: rtl/fetch_stage_fifo.sv
// ============================================================================
//  Module      : fetch_fifo
//  Description : Registered FIFO of fetch entries with flush; head is presented
//                directly from storage.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_fifo
    import types_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     CLK,
    input  logic                     nRST,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  fetch_entry_t             din,
    output fetch_entry_t             head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam logic [c_PTR_W:0] c_FULL = (c_PTR_W + 1)'(DEPTH);

    fetch_entry_t         r_mem [DEPTH];
    logic [c_PTR_W-1:0]   r_wr_ptr;
    logic [c_PTR_W-1:0]   r_rd_ptr;
    logic [c_PTR_W:0]     r_count;

    // Flush wins over any push or pop in the same cycle.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (push) begin
                r_mem[r_wr_ptr] <= din;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count <= r_count + {{c_PTR_W{1'b0}}, push} - {{c_PTR_W{1'b0}}, pop};
        end
    end

    assign head  = r_mem[r_rd_ptr];
    assign count = r_count;
    assign full  = (r_count == c_FULL);
    assign empty = (r_count == '0);

endmodule

`default_nettype wire

// File: rtl/fetch_stage.sv
// ============================================================================
//  Module      : fetch_stage
//  Description : Fetch PC owner; drives icache + BTB lookup, buffers tagged
//                instructions toward decode, handles redirect and squash.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_stage
    import cpu_types::*;
    import types_pkg::*;
#(
    parameter word_t RESET_PC   = 32'h0000_0000,
    parameter int    FIFO_DEPTH = 2
) (
    input  logic        CLK,
    input  logic        nRST,
    output logic        imemREN,
    output logic [31:0] imemaddr,
    input  logic        ihit,
    input  logic [31:0] imemload,
    output logic [31:0] btb_pc_fetch,
    input  logic        btb_hit,
    input  logic        btb_pred_outcome,
    input  logic [31:0] btb_pred_target,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        halt,
    output logic        dec_valid,
    input  logic        dec_ready,
    output logic [31:0] dec_instr,
    output logic [31:0] dec_pc,
    output logic        dec_pred_taken,
    output logic [31:0] dec_pred_target
);

    localparam int               c_CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [c_CNT_W-1:0] c_DEPTH = c_CNT_W'(FIFO_DEPTH);

    fetch_state_t        r_state, w_state_nxt;
    word_t               r_pc, w_pc_nxt;
    word_t               r_saved_pc, w_saved_nxt;
    logic                r_started;
    logic                w_push, w_pop, w_flush;
    logic                w_full, w_empty;
    logic [c_CNT_W-1:0]  w_count;
    word_t               w_redirect_pc;
    logic                w_taken;
    fetch_entry_t        w_din, w_head;

    assign w_redirect_pc = redirect_pc & ~32'd3;
    assign w_taken       = btb_hit & btb_pred_outcome;
    assign w_din         = '{instr: imemload, pc: r_pc, pred_taken: w_taken,
                             pred_target: btb_pred_target};

    // r_started clears asynchronously so the request drops the instant reset
    // asserts, without using the reset net as combinational logic.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state    <= RUN;
            r_pc       <= RESET_PC;
            r_saved_pc <= RESET_PC;
            r_started  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_pc       <= w_pc_nxt;
            r_saved_pc <= w_saved_nxt;
            r_started  <= 1'b1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_saved_nxt = r_saved_pc;
        imemREN     = 1'b0;
        w_push      = 1'b0;
        w_flush     = 1'b0;
        case (r_state)
            RUN: begin
                imemREN = r_started & (w_count < c_DEPTH);
                if (redirect) begin
                    w_flush = 1'b1;
                    if (imemREN && !ihit) begin
                        w_saved_nxt = w_redirect_pc;
                        w_state_nxt = SQUASH;
                    end else begin
                        w_pc_nxt = w_redirect_pc;
                    end
                end else begin
                    if (imemREN && ihit && !w_full) begin
                        w_push   = 1'b1;
                        w_pc_nxt = w_taken ? btb_pred_target : r_pc + 32'd4;
                    end
                    if (halt && (!imemREN || ihit)) begin
                        w_state_nxt = HALTED;
                    end
                end
            end
            SQUASH: begin
                // Address held on the stale pc until the icache completes it.
                imemREN = 1'b1;
                if (redirect) begin
                    w_flush     = 1'b1;
                    w_saved_nxt = w_redirect_pc;
                end
                if (ihit) begin
                    w_pc_nxt    = redirect ? w_redirect_pc : r_saved_pc;
                    w_state_nxt = RUN;
                end
            end
            HALTED: begin
                imemREN = 1'b0;
            end
            default: begin
                w_state_nxt = RUN;
            end
        endcase
    end

    assign imemaddr     = r_pc;
    assign btb_pc_fetch = r_pc;

    assign w_pop     = !w_empty & dec_ready;
    assign dec_valid = !w_empty;

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .CLK   (CLK),
        .nRST  (nRST),
        .push  (w_push),
        .pop   (w_pop),
        .flush (w_flush),
        .din   (w_din),
        .head  (w_head),
        .full  (w_full),
        .empty (w_empty),
        .count (w_count)
    );

    assign dec_instr       = w_head.instr;
    assign dec_pc          = w_head.pc;
    assign dec_pred_taken  = w_head.pred_taken;
    assign dec_pred_target = w_head.pred_target;

endmodule

`default_nettype wire

// File: doc/fetch_stage.md
# fetch_stage

Instruction fetch stage that owns the architectural fetch PC, drives the instruction-cache read port and the branch target buffer lookup in the same cycle, and selects the next PC from the BTB prediction. Fetched words are tagged with their PC and prediction and buffered in a small FIFO toward decode with a valid/ready handshake. A redirect from execute (mispredict or jump) flushes the buffer and restarts fetch; a request already outstanding at the cache is squashed safely.

## Interface
- RESET_PC, 32'h0000_0000, fetch PC after reset
- FIFO_DEPTH, 2, fetch buffer entries (power of two, ≥2)

- CLK  in  1  clock, rising edge
- nRST  in  1  asynchronous reset, active low
- imemREN  out  1  icache read enable
- imemaddr  out  32  icache read address
- ihit  in  1  icache returns imemload this cycle
- imemload  in  32  instruction word
- btb_pc_fetch  out  32  BTB lookup PC (equals imemaddr)
- btb_hit  in  1  BTB tag match for btb_pc_fetch
- btb_pred_outcome  in  1  BTB predicts taken
- btb_pred_target  in  32  BTB predicted target
- redirect  in  1  execute redirect strobe
- redirect_pc  in  32  corrected PC
- halt  in  1  stop fetching (level)
- dec_valid  out  1  FIFO head valid
- dec_ready  in  1  decode accepts head
- dec_instr  out  32  head instruction
- dec_pc  out  32  head PC
- dec_pred_taken  out  1  head predicted taken
- dec_pred_target  out  32  head predicted target

## Operation
- Reset values: pc=RESET_PC, state RUN, FIFO empty; imemREN=0, dec_valid=0, all dec_* data 0.
- FSM states:
  - RUN: imemREN=1 iff FIFO count<FIFO_DEPTH; imemaddr=btb_pc_fetch=pc.
  - SQUASH: imemREN=1, imemaddr holds the stale pc; waiting for the stale ihit.
  - HALTED: imemREN=0 until reset.
- Request rule: once imemREN=1, imemaddr stays stable until ihit. The icache must never see an address change mid-miss.
- RUN, ihit, no redirect:
  - Push {imemload, pc, taken, btb_pred_target}, where taken = btb_hit & btb_pred_outcome.
  - pc ← taken ? btb_pred_target : pc+4 (32-bit wrap; 0xFFFF_FFFC → 0).
- Redirect in RUN:
  - FIFO flushed, including any entry popped or pushed that cycle; an ihit that cycle is discarded.
  - If imemREN=1 & !ihit: save redirect_pc, go to SQUASH.
  - Otherwise: pc ← redirect_pc, stay RUN.
  - redirect_pc[1:0] is forced to 0.
- SQUASH:
  - On ihit: discard the word, pc ← saved PC, go to RUN.
  - A further redirect during SQUASH overwrites the saved PC and re-flushes.
- Halt:
  - In RUN with halt=1, if imemREN=0 or ihit: go to HALTED. Any completing ihit is still pushed unless redirect is also set.
  - Redirect has priority over halt in the same cycle.
  - HALTED ignores redirect; the FIFO still drains to decode.
- FIFO:
  - Pop when dec_valid & dec_ready.
  - Push and pop in the same cycle are both honoured.
  - Push never occurs when full, because imemREN is gated.

## Timing
- BTB lookup is combinational in the same cycle as imemaddr.
- ihit in cycle N → entry on dec_* in N+1 (registered FIFO).
- Steady state: 1 instruction/cycle when ihit=1 every cycle and dec_ready=1.
- Redirect in cycle N, no outstanding miss → dec_valid=0 and imemaddr=redirect_pc in N+1.
- Redirect with outstanding miss → imemaddr=redirect_pc the cycle after the stale ihit.
- Full FIFO → imemREN=0 the same cycle the count reaches FIFO_DEPTH. imemREN never depends combinationally on dec_ready.
- Reset mid-miss: imemREN drops immediately (async); fetch restarts at RESET_PC.

## Structure
- types_pkg: fetch_entry_t packed struct {word_t instr; word_t pc; logic pred_taken; word_t pred_target}, and fetch_state_t enum {RUN, SQUASH, HALTED}. word_t comes from cpu_types.
- Sub-module fetch_fifo: parameterised FIFO of fetch_entry_t with push, pop, flush, full, empty and count. The same async nRST resets it.

## Test plan
- Reset, then ihit every cycle, BTB miss, dec_ready=1 → imemaddr 0x0,0x4,0x8…; dec_pc 0x0 appears one cycle after the first ihit; dec_pred_taken=0.
- BTB hit, taken, target 0x40 at pc 0x8 → next imemaddr 0x40; entry at 0x8 carries pred_taken=1, pred_target=0x40.
- dec_ready=0 with continuous ihit → two entries buffered, imemREN=0; one pop → imemREN=1 the next cycle; no entry is lost or duplicated.
- Redirect to 0x103 while imemREN=1, ihit=0 → SQUASH, imemaddr stays stable; stale ihit 3 cycles later is discarded; imemaddr=0x100; FIFO is empty throughout.
- Redirect coincident with ihit and pop → FIFO empty next cycle; imemaddr=redirect_pc; no stale entry reaches decode.
- halt during a miss → HALTED only after ihit, that word is delivered, then imemREN=0 permanently; nRST low mid-state → pc=RESET_PC, dec_valid=0.
